regfile_write_scheduler: RTL and testbench

- Producer side of the register-file write port.
- Accepts register writeback requests from the execute/memory pipeline over a valid/ready handshake.
- Buffers them in a small in-order queue and issues at most one write per cycle to the register file (write enable, destination address, data).
- Provides a newest-wins forwarding lookup over pending writes so decode can read values not yet committed.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/regfile_write_scheduler.sv | 91 +++++++++
 tb/tb_regfile_write_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, well-known registers and the writeback request type.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO     = '0;
    localparam logic [REG_ADDR_W-1:0] REG_SP       = 5'd29;
    localparam logic [REG_DATA_W-1:0] SP_RESET_VAL = 32'h0000_8000;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of writeback requests; also exposes every slot, oldest first,
// so the owner can scan pending writes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    push_i,
    input  wb_req_t                 push_entry_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [CNT_W-1:0]        count_o,
    output wb_req_t                 head_o,
    output wb_req_t [DEPTH-1:0]     entries_o,
    output logic    [DEPTH-1:0]     valid_o
);

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot k of the view is the k-th oldest entry; the last valid slot is the youngest.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
            valid_o[k]   = (CNT_W'(k) < count_q);
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write port scheduler: queues writebacks, issues one per cycle, forwards pending
// values. Define WB_SCHED_TRACE_EN to print issued writes and dropped $0 requests.
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              rf_hold,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    input  logic [ADDR_W-1:0] fwd_addr_s1,
    input  logic [ADDR_W-1:0] fwd_addr_s2,
    output logic              fwd_hit_s1,
    output logic              fwd_hit_s2,
    output logic [DATA_W-1:0] fwd_data_s1,
    output logic [DATA_W-1:0] fwd_data_s2,
    output logic [CNT_W-1:0]  pending_cnt
);

    logic                   full, empty, push, accept;
    wb_req_t                push_entry, head;
    wb_req_t [DEPTH-1:0]    entries;
    logic    [DEPTH-1:0]    valid;

    assign req_ready       = !full;
    assign accept          = req_valid && req_ready;
    assign push            = accept && !is_zero_reg(REG_ADDR_W'(req_addr));
    assign push_entry.addr = REG_ADDR_W'(req_addr);
    assign push_entry.data = REG_DATA_W'(req_data);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i      (clock),
        .reset_i      (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (rf_w_en),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (pending_cnt),
        .head_o       (head),
        .entries_o    (entries),
        .valid_o      (valid)
    );

    assign rf_w_en   = !empty && !rf_hold;
    assign rf_w_addr = empty ? '0 : ADDR_W'(head.addr);
    assign rf_w_data = empty ? '0 : DATA_W'(head.data);

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_hit_s1  = 1'b0;
        fwd_hit_s2  = 1'b0;
        fwd_data_s1 = '0;
        fwd_data_s2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && fwd_addr_s1 != '0 && ADDR_W'(entries[k].addr) == fwd_addr_s1) begin
                fwd_hit_s1  = 1'b1;
                fwd_data_s1 = DATA_W'(entries[k].data);
            end
            if (valid[k] && fwd_addr_s2 != '0 && ADDR_W'(entries[k].addr) == fwd_addr_s2) begin
                fwd_hit_s2  = 1'b1;
                fwd_data_s2 = DATA_W'(entries[k].data);
            end
        end
    end

`ifdef WB_SCHED_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset && rf_w_en) begin
            $display("[wb_sched] write r%0d = 0x%h", rf_w_addr, rf_w_data);
        end
        if (!reset && accept && !push) begin
            $display("[wb_sched] drop write to r0 (data 0x%h)", req_data);
        end
    end
`else
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: scoreboard of accepted writes checked
// against every issued write, plus directed scenario tasks.
module tb_regfile_write_scheduler;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              rf_hold = 1'b0;
    logic              rf_w_en;
    logic [ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0] rf_w_data;
    logic [ADDR_W-1:0] fwd_addr_s1 = '0;
    logic [ADDR_W-1:0] fwd_addr_s2 = '0;
    logic              fwd_hit_s1, fwd_hit_s2;
    logic [DATA_W-1:0] fwd_data_s1, fwd_data_s2;
    logic [CNT_W-1:0]  pending_cnt;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   cycle = 0;
    exp_t sb[$];
    int   issue_addr[$];
    int   issue_cyc[$];

    regfile_write_scheduler #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_hold     (rf_hold),
        .rf_w_en     (rf_w_en),
        .rf_w_addr   (rf_w_addr),
        .rf_w_data   (rf_w_data),
        .fwd_addr_s1 (fwd_addr_s1),
        .fwd_addr_s2 (fwd_addr_s2),
        .fwd_hit_s1  (fwd_hit_s1),
        .fwd_hit_s2  (fwd_hit_s2),
        .fwd_data_s1 (fwd_data_s1),
        .fwd_data_s2 (fwd_data_s2),
        .pending_cnt (pending_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    // Every issued write must match the oldest accepted, not-yet-issued request.
    always @(negedge clock) begin
        if (!reset && rf_w_en) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL issue_unexpected: wrote r%0d=0x%h, expected no write",
                         rf_w_addr, rf_w_data);
            end else begin
                if (rf_w_addr !== sb[0].addr || rf_w_data !== sb[0].data) begin
                    tests_failed++;
                    $display("FAIL issue_order: got r%0d=0x%h, expected r%0d=0x%h",
                             rf_w_addr, rf_w_data, sb[0].addr, sb[0].data);
                end
                void'(sb.pop_front());
            end
            issue_addr.push_back(int'(rf_w_addr));
            issue_cyc.push_back(cycle);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // One-cycle attempt; request enters the scoreboard only after its accepting edge.
    task automatic try_send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output bit acc);
        exp_t e;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        @(negedge clock);
        acc = req_ready;
        @(posedge clock);
        #1;
        if (acc && a != '0) begin
            e.addr = a;
            e.data = d;
            sb.push_back(e);
        end
        req_valid = 1'b0;
    endtask

    task automatic send_wait(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input int max_cyc, output bit acc);
        acc = 1'b0;
        for (int i = 0; i < max_cyc && !acc; i++) begin
            try_send(a, d, acc);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && pending_cnt == '0) break;
            @(posedge clock);
            #1;
        end
        tests_run++;
        if (sb.size() != 0 || pending_cnt !== '0) begin
            tests_failed++;
            $display("FAIL %s_drain: pending_cnt=%0d sb=%0d, expected 0 and 0",
                     name, pending_cnt, sb.size());
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run += 4;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got %b, expected 1", req_ready);
        end
        if (rf_w_en !== 1'b0 || rf_w_addr !== '0 || rf_w_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_write: got en=%b addr=%0d data=0x%h, expected 0/0/0",
                     rf_w_en, rf_w_addr, rf_w_data);
        end
        if (pending_cnt !== '0) begin
            tests_failed++; $display("FAIL reset_cnt: got %0d, expected 0", pending_cnt);
        end
        if (fwd_hit_s1 !== 1'b0 || fwd_hit_s2 !== 1'b0 || fwd_data_s1 !== '0
            || fwd_data_s2 !== '0) begin
            tests_failed++;
            $display("FAIL reset_fwd: got hits %b%b data 0x%h 0x%h, expected all 0",
                     fwd_hit_s1, fwd_hit_s2, fwd_data_s1, fwd_data_s2);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit acc;
        rf_hold = 1'b0;
        try_send(5'd5, 32'hDEAD_BEEF, acc);
        tests_run += 4;
        if (!acc) begin
            tests_failed++; $display("FAIL single_accept: got ready=0, expected 1");
        end
        if (pending_cnt !== CNT_W'(1)) begin
            tests_failed++; $display("FAIL single_cnt: got %0d, expected 1", pending_cnt);
        end
        @(negedge clock);
        if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd5 || rf_w_data !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_issue: got en=%b r%0d=0x%h, expected 1 r5=0xdeadbeef",
                     rf_w_en, rf_w_addr, rf_w_data);
        end
        @(posedge clock);
        #1;
        if (pending_cnt !== '0 || rf_w_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_empty: got cnt=%0d en=%b, expected 0 0", pending_cnt, rf_w_en);
        end
    endtask

    task automatic test_zero_drop();
        bit acc;
        try_send(5'd0, 32'h1234, acc);
        tests_run += 2;
        if (!acc) begin
            tests_failed++; $display("FAIL zero_accept: got ready=0, expected 1");
        end
        if (pending_cnt !== '0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_cnt: got cnt=%0d ready=%b, expected 0 1", pending_cnt, req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if (rf_w_en !== 1'b0) begin
                tests_failed++; $display("FAIL zero_issue: got en=1, expected 0");
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_hold_fill();
        bit acc;
        rf_hold = 1'b1;
        issue_addr.delete();
        issue_cyc.delete();
        for (int a = 1; a <= 4; a++) begin
            try_send(ADDR_W'(a), DATA_W'(32'h100 + a), acc);
            tests_run++;
            if (!acc) begin
                tests_failed++; $display("FAIL fill_accept_%0d: got ready=0, expected 1", a);
            end
        end
        try_send(5'd5, 32'h105, acc);
        tests_run += 2;
        if (acc) begin
            tests_failed++; $display("FAIL fill_full_accept: got ready=1, expected 0");
        end
        if (pending_cnt !== CNT_W'(DEPTH) || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: got cnt=%0d ready=%b, expected %0d 0",
                     pending_cnt, req_ready, DEPTH);
        end
        rf_hold = 1'b0;
        send_wait(5'd5, 32'h105, 8, acc);
        tests_run++;
        if (!acc) begin
            tests_failed++; $display("FAIL fill_late_accept: got never ready, expected accept");
        end
        drain("fill");
        tests_run += 2;
        if (issue_addr.size() != 5) begin
            tests_failed++;
            $display("FAIL fill_issue_count: got %0d, expected 5", issue_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (issue_addr[i] != i + 1) begin
                    tests_failed++;
                    $display("FAIL fill_issue_seq: slot %0d got r%0d, expected r%0d",
                             i, issue_addr[i], i + 1);
                    break;
                end
            end
            if (issue_cyc[3] - issue_cyc[0] != 3) begin
                tests_failed++;
                $display("FAIL fill_issue_gap: got span %0d cycles, expected 3",
                         issue_cyc[3] - issue_cyc[0]);
            end
        end
    endtask

    task automatic test_forward();
        bit acc;
        exp_t e;
        rf_hold = 1'b1;
        try_send(5'd7, 32'hA, acc);
        try_send(5'd7, 32'hB, acc);
        try_send(5'd9, 32'hC, acc);
        fwd_addr_s1 = 5'd7;
        fwd_addr_s2 = 5'd0;
        #1;
        tests_run += 5;
        if (fwd_hit_s1 !== 1'b1 || fwd_data_s1 !== 32'hB) begin
            tests_failed++;
            $display("FAIL fwd_newest: got hit=%b data=0x%h, expected 1 0xb",
                     fwd_hit_s1, fwd_data_s1);
        end
        if (fwd_hit_s2 !== 1'b0 || fwd_data_s2 !== '0) begin
            tests_failed++;
            $display("FAIL fwd_zero: got hit=%b data=0x%h, expected 0 0", fwd_hit_s2, fwd_data_s2);
        end
        fwd_addr_s1 = 5'd3;
        fwd_addr_s2 = 5'd9;
        #1;
        if (fwd_hit_s1 !== 1'b0 || fwd_data_s1 !== '0) begin
            tests_failed++;
            $display("FAIL fwd_miss: got hit=%b data=0x%h, expected 0 0", fwd_hit_s1, fwd_data_s1);
        end
        if (fwd_hit_s2 !== 1'b1 || fwd_data_s2 !== 32'hC) begin
            tests_failed++;
            $display("FAIL fwd_s2: got hit=%b data=0x%h, expected 1 0xc", fwd_hit_s2, fwd_data_s2);
        end
        // A request in flight this cycle must not be visible yet.
        fwd_addr_s1 = 5'd11;
        req_valid = 1'b1;
        req_addr  = 5'd11;
        req_data  = 32'h11;
        #1;
        if (fwd_hit_s1 !== 1'b0) begin
            tests_failed++; $display("FAIL fwd_inflight: got hit=1, expected 0");
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        e.addr = 5'd11;
        e.data = 32'h11;
        sb.push_back(e);
        tests_run++;
        if (fwd_hit_s1 !== 1'b1 || fwd_data_s1 !== 32'h11) begin
            tests_failed++;
            $display("FAIL fwd_after_accept: got hit=%b data=0x%h, expected 1 0x11",
                     fwd_hit_s1, fwd_data_s1);
        end
        rf_hold = 1'b0;
        drain("fwd");
        fwd_addr_s1 = '0;
        fwd_addr_s2 = '0;
    endtask

    task automatic test_back_to_back();
        bit acc;
        rf_hold = 1'b0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            try_send(ADDR_W'((i % 31) + 1), $urandom, acc);
            tests_run += 2;
            if (!acc) begin
                tests_failed++; $display("FAIL b2b_accept_%0d: got ready=0, expected 1", i);
            end
            if (pending_cnt > CNT_W'(1)) begin
                tests_failed++;
                $display("FAIL b2b_cnt_%0d: got %0d, expected <=1", i, pending_cnt);
            end
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        bit acc;
        rf_hold = 1'b1;
        try_send(5'd3, 32'h33, acc);
        try_send(5'd4, 32'h44, acc);
        try_send(5'd6, 32'h66, acc);
        fwd_addr_s1 = 5'd3;
        #1;
        tests_run += 2;
        if (pending_cnt !== CNT_W'(3) || fwd_hit_s1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pre: got cnt=%0d hit=%b, expected 3 1", pending_cnt, fwd_hit_s1);
        end
        reset = 1'b1;
        #1;
        if (pending_cnt !== '0 || rf_w_en !== 1'b0 || fwd_hit_s1 !== 1'b0
            || req_ready !== 1'b1 || rf_w_addr !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_clear: got cnt=%0d en=%b hit=%b ready=%b addr=%0d, expected 0 0 0 1 0",
                     pending_cnt, rf_w_en, fwd_hit_s1, req_ready, rf_w_addr);
        end
        sb.delete();
        @(posedge clock);
        #1;
        reset   = 1'b0;
        rf_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if (rf_w_en !== 1'b0 || pending_cnt !== '0) begin
                tests_failed++;
                $display("FAIL rstmid_after: got en=%b cnt=%0d, expected 0 0", rf_w_en, pending_cnt);
            end
        end
        @(posedge clock);
        #1;
        fwd_addr_s1 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_drop();
        test_hold_fill();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
